// File: rtl/vital_pkg.sv
// Shared types and constants for the vital alarm monitor slice.
// Optional sample-stall detection in the top is enabled with VITAL_TIMEOUT_EN.
package vital_pkg;

    localparam int SAMPLE_W = 7;

    localparam logic [SAMPLE_W-1:0] LIMIT_LOW_RST  = 7'd0;
    localparam logic [SAMPLE_W-1:0] LIMIT_HIGH_RST = 7'd127;

    typedef enum logic [1:0] {
        NORMAL,
        SUSPECT,
        ALARM
    } state_t;

    typedef enum logic [1:0] {
        IN_RANGE,
        BELOW,
        ABOVE
    } class_t;

endpackage

// File: rtl/vital_classifier.sv
// Combinational range check of a sample against the latched limits.
// An inverted limit pair makes every sample read as in range.
import vital_pkg::*;

module vital_classifier (
    input  logic [SAMPLE_W-1:0] sample,
    input  logic [SAMPLE_W-1:0] limit_low,
    input  logic [SAMPLE_W-1:0] limit_high,
    input  logic                cfg_error,
    output class_t              cls
);

    always_comb begin
        cls = IN_RANGE;
        if (!cfg_error) begin
            if (sample < limit_low) begin
                cls = BELOW;
            end else if (sample > limit_high) begin
                cls = ABOVE;
            end
        end
    end

endmodule

// File: rtl/vital_alarm_monitor.sv
// Debounced, directional, latched vital-sign alarm with a saturating event counter.
// Define VITAL_TIMEOUT_EN to build the sensor_fault stall detector; otherwise it is tied low.
import vital_pkg::*;

module vital_alarm_monitor #(
    parameter int CONFIRM_COUNT  = 3,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int EVT_W          = 8
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                cfg_load,
    input  logic [SAMPLE_W-1:0] limit_low,
    input  logic [SAMPLE_W-1:0] limit_high,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] sample,
    input  logic                alarm_ack,
    output logic                alarm,
    output logic                alarm_high,
    output logic                alarm_low,
    output logic                suspect,
    output logic                cfg_error,
    output logic [EVT_W-1:0]    event_count,
    output logic                sensor_fault
);

    localparam logic [3:0] CONFIRM = 4'(CONFIRM_COUNT);

    logic [SAMPLE_W-1:0] low_q;
    logic [SAMPLE_W-1:0] high_q;
    class_t              cls;
    state_t              state;
    state_t              state_n;
    logic [3:0]          count;
    logic [3:0]          count_n;
    logic [3:0]          count_inc;
    logic                dir_high;
    logic                dir_high_n;
    logic                valid_oor;
    logic                is_above;

    vital_classifier u_classifier (
        .sample     (sample),
        .limit_low  (low_q),
        .limit_high (high_q),
        .cfg_error  (cfg_error),
        .cls        (cls)
    );

    assign valid_oor = sample_valid && (cls != IN_RANGE);
    assign is_above  = (cls == ABOVE);
    assign count_inc = count + 4'd1;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            low_q     <= LIMIT_LOW_RST;
            high_q    <= LIMIT_HIGH_RST;
            cfg_error <= 1'b0;
        end else if (cfg_load) begin
            low_q     <= limit_low;
            high_q    <= limit_high;
            cfg_error <= (limit_low > limit_high);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= NORMAL;
            count    <= 4'd0;
            dir_high <= 1'b0;
        end else begin
            state    <= state_n;
            count    <= count_n;
            dir_high <= dir_high_n;
        end
    end

    // The direction is re-recorded whenever a debounce run starts or flips.
    always_comb begin
        state_n    = state;
        count_n    = count;
        dir_high_n = dir_high;
        unique case (state)
            NORMAL: begin
                if (valid_oor) begin
                    dir_high_n = is_above;
                    count_n    = 4'd1;
                    state_n    = (CONFIRM == 4'd1) ? ALARM : SUSPECT;
                end
            end
            SUSPECT: begin
                if (sample_valid) begin
                    if (cls == IN_RANGE) begin
                        state_n = NORMAL;
                        count_n = 4'd0;
                    end else if (is_above == dir_high) begin
                        count_n = count_inc;
                        if (count_inc >= CONFIRM) begin
                            state_n = ALARM;
                        end
                    end else begin
                        count_n    = 4'd1;
                        dir_high_n = is_above;
                    end
                end
            end
            ALARM: begin
                if (alarm_ack) begin
                    if (valid_oor) begin
                        state_n    = SUSPECT;
                        count_n    = 4'd1;
                        dir_high_n = is_above;
                    end else begin
                        state_n = NORMAL;
                        count_n = 4'd0;
                    end
                end
            end
            default: begin
                state_n = NORMAL;
                count_n = 4'd0;
            end
        endcase
        if (cfg_load && (state != ALARM)) begin
            state_n = NORMAL;
            count_n = 4'd0;
        end
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            alarm       <= 1'b0;
            alarm_high  <= 1'b0;
            alarm_low   <= 1'b0;
            suspect     <= 1'b0;
            event_count <= '0;
        end else begin
            alarm      <= (state_n == ALARM);
            alarm_high <= (state_n == ALARM) && dir_high_n;
            alarm_low  <= (state_n == ALARM) && !dir_high_n;
            suspect    <= (state_n == SUSPECT);
            if ((state_n == ALARM) && (state != ALARM) && (event_count != '1)) begin
                event_count <= event_count + {{(EVT_W-1){1'b0}}, 1'b1};
            end
        end
    end

`ifdef VITAL_TIMEOUT_EN
    localparam int                IDLE_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT_CYCLES);

    logic [IDLE_W-1:0] idle_count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            idle_count   <= '0;
            sensor_fault <= 1'b0;
        end else if (sample_valid) begin
            idle_count   <= '0;
            sensor_fault <= 1'b0;
        end else begin
            if (idle_count != IDLE_MAX) begin
                idle_count <= idle_count + IDLE_W'(1);
            end
            sensor_fault <= (idle_count >= (IDLE_MAX - IDLE_W'(1)));
        end
    end
`else
    assign sensor_fault = 1'b0;
`endif

endmodule

// File: tb/tb_vital_alarm_monitor.sv
// Scoreboard bench for vital_alarm_monitor: each step queues its expected outputs,
// which are popped and compared one cycle later. Timeout checks need VITAL_TIMEOUT_EN.
module tb_vital_alarm_monitor;

    typedef struct packed {
        logic       alarm;
        logic       alarm_high;
        logic       alarm_low;
        logic       suspect;
        logic       cfg_error;
        logic       sensor_fault;
        logic [7:0] evt;
    } obs_t;

    typedef struct packed {
        logic       valid;
        logic [6:0] sample;
        logic       ack;
        logic       cfg;
        logic [6:0] lo;
        logic [6:0] hi;
        obs_t       exp;
    } stim_t;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       cfg_load = 1'b0;
    logic [6:0] limit_low = '0;
    logic [6:0] limit_high = '0;
    logic       sample_valid = 1'b0;
    logic [6:0] sample = '0;
    logic       alarm_ack = 1'b0;
    logic       alarm;
    logic       alarm_high;
    logic       alarm_low;
    logic       suspect;
    logic       cfg_error;
    logic [7:0] event_count;
    logic       sensor_fault;
    obs_t       obs;

    obs_t exp_q[$];
    int   total = 0;
    int   bad = 0;

    vital_alarm_monitor #(
        .CONFIRM_COUNT  (3),
        .TIMEOUT_CYCLES (16),
        .EVT_W          (8)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .cfg_load     (cfg_load),
        .limit_low    (limit_low),
        .limit_high   (limit_high),
        .sample_valid (sample_valid),
        .sample       (sample),
        .alarm_ack    (alarm_ack),
        .alarm        (alarm),
        .alarm_high   (alarm_high),
        .alarm_low    (alarm_low),
        .suspect      (suspect),
        .cfg_error    (cfg_error),
        .event_count  (event_count),
        .sensor_fault (sensor_fault)
    );

    always #5 clock = ~clock;

    assign obs = {alarm, alarm_high, alarm_low, suspect, cfg_error, sensor_fault, event_count};

    function automatic stim_t st(input logic v, input logic [6:0] s, input logic ack,
                                 input logic cfg, input logic [6:0] lo, input logic [6:0] hi,
                                 input logic a, input logic ah, input logic al,
                                 input logic su, input logic ce, input int evt);
        stim_t r;
        r.valid  = v;
        r.sample = s;
        r.ack    = ack;
        r.cfg    = cfg;
        r.lo     = lo;
        r.hi     = hi;
        r.exp    = {a, ah, al, su, ce, 1'b0, 8'(evt)};
        return r;
    endfunction

    task automatic applyStimulus(input stim_t s);
        sample_valid = s.valid;
        sample       = s.sample;
        alarm_ack    = s.ack;
        cfg_load     = s.cfg;
        limit_low    = s.lo;
        limit_high   = s.hi;
    endtask

    task automatic test_reset();
        obs_t e;
        reset_n = 1'b0;
        applyStimulus(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        exp_q.push_back('0);
        repeat (2) @(posedge clock);
        #1;
        e = exp_q.pop_front();
        total++;
        if (obs !== e) begin
            bad++;
            $display("[TB] FAIL reset: got %b need %b", obs, e);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_in_range();
        stim_t seq[$];
        obs_t  e;
        seq.push_back(st(0, 0,   0, 1, 60, 100, 0, 0, 0, 0, 0, 0));
        seq.push_back(st(1, 80,  0, 0, 0, 0,    0, 0, 0, 0, 0, 0));
        seq.push_back(st(1, 60,  0, 0, 0, 0,    0, 0, 0, 0, 0, 0));
        seq.push_back(st(1, 100, 0, 0, 0, 0,    0, 0, 0, 0, 0, 0));
        foreach (seq[i]) begin
            applyStimulus(seq[i]);
            exp_q.push_back(seq[i].exp);
            @(posedge clock);
            #1;
            e = exp_q.pop_front();
            total++;
            if (obs !== e) begin
                bad++;
                $display("[TB] FAIL in_range[%0d]: got %b need %b", i, obs, e);
            end
        end
    endtask

    task automatic test_alarm_high();
        stim_t seq[$];
        obs_t  e;
        seq.push_back(st(1, 110, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        seq.push_back(st(1, 115, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        seq.push_back(st(1, 120, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1));
        seq.push_back(st(1, 10,  0, 0, 0, 0, 1, 1, 0, 0, 0, 1));
        seq.push_back(st(0, 0,   1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        foreach (seq[i]) begin
            applyStimulus(seq[i]);
            exp_q.push_back(seq[i].exp);
            @(posedge clock);
            #1;
            e = exp_q.pop_front();
            total++;
            if (obs !== e) begin
                bad++;
                $display("[TB] FAIL alarm_high[%0d]: got %b need %b", i, obs, e);
            end
        end
    endtask

    task automatic test_flip_and_low();
        stim_t seq[$];
        obs_t  e;
        seq.push_back(st(1, 50,  0, 0, 0, 0, 0, 0, 0, 1, 0, 1));
        seq.push_back(st(1, 105, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1));
        seq.push_back(st(1, 50,  0, 0, 0, 0, 0, 0, 0, 1, 0, 1));
        seq.push_back(st(1, 50,  0, 0, 0, 0, 0, 0, 0, 1, 0, 1));
        seq.push_back(st(1, 50,  0, 0, 0, 0, 1, 0, 1, 0, 0, 2));
        seq.push_back(st(1, 120, 1, 0, 0, 0, 0, 0, 0, 1, 0, 2));
        seq.push_back(st(1, 80,  0, 0, 0, 0, 0, 0, 0, 0, 0, 2));
        foreach (seq[i]) begin
            applyStimulus(seq[i]);
            exp_q.push_back(seq[i].exp);
            @(posedge clock);
            #1;
            e = exp_q.pop_front();
            total++;
            if (obs !== e) begin
                bad++;
                $display("[TB] FAIL flip_low[%0d]: got %b need %b", i, obs, e);
            end
        end
    endtask

    task automatic test_cfg_error();
        stim_t seq[$];
        obs_t  e;
        seq.push_back(st(0, 0,   0, 1, 100, 60, 0, 0, 0, 0, 1, 2));
        for (int k = 0; k < 4; k++) begin
            seq.push_back(st(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2));
        end
        seq.push_back(st(0, 0,   0, 1, 60, 100, 0, 0, 0, 0, 0, 2));
        seq.push_back(st(1, 120, 0, 0, 0, 0,    0, 0, 0, 1, 0, 2));
        seq.push_back(st(0, 0,   0, 1, 60, 100, 0, 0, 0, 0, 0, 2));
        seq.push_back(st(1, 120, 0, 0, 0, 0,    0, 0, 0, 1, 0, 2));
        seq.push_back(st(1, 80,  0, 0, 0, 0,    0, 0, 0, 0, 0, 2));
        foreach (seq[i]) begin
            applyStimulus(seq[i]);
            exp_q.push_back(seq[i].exp);
            @(posedge clock);
            #1;
            e = exp_q.pop_front();
            total++;
            if (obs !== e) begin
                bad++;
                $display("[TB] FAIL cfg_error[%0d]: got %b need %b", i, obs, e);
            end
        end
    endtask

    task automatic test_reset_mid();
        stim_t pre[$];
        stim_t post[$];
        obs_t  e;
        pre.push_back(st(1, 120, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2));
        pre.push_back(st(1, 120, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2));
        foreach (pre[i]) begin
            applyStimulus(pre[i]);
            exp_q.push_back(pre[i].exp);
            @(posedge clock);
            #1;
            e = exp_q.pop_front();
            total++;
            if (obs !== e) begin
                bad++;
                $display("[TB] FAIL reset_mid_pre[%0d]: got %b need %b", i, obs, e);
            end
        end
        applyStimulus(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        reset_n = 1'b0;
        exp_q.push_back('0);
        #2;
        e = exp_q.pop_front();
        total++;
        if (obs !== e) begin
            bad++;
            $display("[TB] FAIL reset_mid_async: got %b need %b", obs, e);
        end
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        post.push_back(st(1, 127, 0, 0, 0, 0,    0, 0, 0, 0, 0, 0));
        post.push_back(st(1, 0,   0, 0, 0, 0,    0, 0, 0, 0, 0, 0));
        post.push_back(st(0, 0,   0, 1, 60, 100, 0, 0, 0, 0, 0, 0));
        post.push_back(st(1, 120, 0, 0, 0, 0,    0, 0, 0, 1, 0, 0));
        post.push_back(st(1, 120, 0, 0, 0, 0,    0, 0, 0, 1, 0, 0));
        post.push_back(st(1, 80,  0, 0, 0, 0,    0, 0, 0, 0, 0, 0));
        foreach (post[i]) begin
            applyStimulus(post[i]);
            exp_q.push_back(post[i].exp);
            @(posedge clock);
            #1;
            e = exp_q.pop_front();
            total++;
            if (obs !== e) begin
                bad++;
                $display("[TB] FAIL reset_mid_post[%0d]: got %b need %b", i, obs, e);
            end
        end
    endtask

    task automatic test_saturation();
        stim_t seq[$];
        obs_t  e;
        int    evt;
        for (int k = 0; k < 260; k++) begin
            evt = (k + 1 > 255) ? 255 : k + 1;
            seq.push_back(st(1, 120, 0, 0, 0, 0, 0, 0, 0, 1, 0, (k > 255) ? 255 : k));
            seq.push_back(st(1, 120, 0, 0, 0, 0, 0, 0, 0, 1, 0, (k > 255) ? 255 : k));
            seq.push_back(st(1, 120, 0, 0, 0, 0, 1, 1, 0, 0, 0, evt));
            seq.push_back(st(0, 0,   1, 0, 0, 0, 0, 0, 0, 0, 0, evt));
        end
        foreach (seq[i]) begin
            applyStimulus(seq[i]);
            exp_q.push_back(seq[i].exp);
            @(posedge clock);
            #1;
            e = exp_q.pop_front();
            total++;
            if (obs !== e) begin
                bad++;
                $display("[TB] FAIL saturation[%0d]: got %b need %b", i, obs, e);
            end
        end
    endtask

`ifdef VITAL_TIMEOUT_EN
    task automatic test_timeout();
        stim_t seq[$];
        stim_t s;
        obs_t  e;
        seq.push_back(st(1, 120, 0, 0, 0, 0, 0, 0, 0, 1, 0, 255));
        seq.push_back(st(1, 120, 0, 0, 0, 0, 0, 0, 0, 1, 0, 255));
        seq.push_back(st(1, 120, 0, 0, 0, 0, 1, 1, 0, 0, 0, 255));
        for (int k = 1; k <= 16; k++) begin
            s = st(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 255);
            s.exp.sensor_fault = (k == 16);
            seq.push_back(s);
        end
        seq.push_back(st(1, 80, 0, 0, 0, 0, 1, 1, 0, 0, 0, 255));
        seq.push_back(st(1, 80, 1, 0, 0, 0, 0, 0, 0, 0, 0, 255));
        foreach (seq[i]) begin
            applyStimulus(seq[i]);
            exp_q.push_back(seq[i].exp);
            @(posedge clock);
            #1;
            e = exp_q.pop_front();
            total++;
            if (obs !== e) begin
                bad++;
                $display("[TB] FAIL timeout[%0d]: got %b need %b", i, obs, e);
            end
        end
    endtask
`endif

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_in_range();
        test_alarm_high();
        test_flip_and_low();
        test_cfg_error();
        test_reset_mid();
        test_saturation();
`ifdef VITAL_TIMEOUT_EN
        test_timeout();
`endif
        applyStimulus(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
